cr_byte_stuffer: RTL and testbench
==================================

Name: cr_byte_stuffer

Overview:
- Receives the 32-bit Huffman bitstream words produced by the Cr DCT/quantize/Huffman pipeline (JPEG_bitstream / data_ready), plus the end-of-block partial-word flush (bit count and end_of_block_empty).
- Serializes the words into a byte stream, MSB first.
- Inserts the JPEG stuffing byte 0x00 after every 0xFF and pads flushed partial words with 1s to a byte boundary.
- Output is a valid/ready byte interface feeding the file/header assembler.

Parameters:
- FIFO_DEPTH, 4, number of input word entries buffered (power of 2, min 2).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- word_valid  input  1  full 32-bit word present on word_in (Huffman data_ready).
- word_in  input  32  bitstream word, bit 31 first.
- eob_flush  input  1  end-of-block partial flush strobe (end_of_block_empty).
- flush_bits  input  5  valid MSB-aligned bits in word_in on a flush, 0..31 (Huffman output_reg_count).
- in_ready  output  1  FIFO can accept an entry this cycle.
- byte_out  output  8  output byte.
- byte_valid  output  1  byte_out valid.
- byte_ready  input  1  downstream accepts byte_out.
- busy  output  1  FIFO non-empty or FSM not IDLE.
- overflow  output  1  sticky; an entry arrived while in_ready=0.

Behaviour:
- Reset (rst=0, async):
  - FIFO emptied, FSM to IDLE, shift register cleared.
  - byte_out=0x00, byte_valid=0, in_ready=1, busy=0, overflow=0.
- FIFO entry format: {word[31:0], nbits[5:0]}.
  - word_valid alone pushes nbits=32.
  - eob_flush with flush_bits=N>0 pushes nbits=N.
  - eob_flush with N=0 pushes nothing.
  - eob_flush and word_valid in the same cycle: eob_flush wins; one entry is pushed with nbits=flush_bits.
- in_ready = !full (registered on FIFO count).
  - Push while full: entry dropped, FIFO unchanged, overflow set until reset.
- Simultaneous push and pop when full: the pop frees the slot, but in_ready was 0, so the push is still dropped and flagged.
- FSM states: IDLE, EMIT, STUFF.
  - IDLE: if FIFO non-empty, pop the head into the 32-bit shift register sreg.
    - Padding: bits below nbits are forced to 1.
    - Byte counter bcnt = ceil(nbits/8), range 1..4.
    - Go to EMIT.
  - EMIT: byte_valid=1, byte_out=sreg[31:24]. On byte_ready:
    - If the byte is 0xFF, go to STUFF.
    - Otherwise shift sreg left 8 and decrement bcnt.
    - If bcnt reaches 0, pop the next entry directly when available (stay in EMIT), else go to IDLE.
  - STUFF: byte_valid=1, byte_out=0x00. On byte_ready, perform the shift/decrement/next decision deferred from EMIT.
- Latency and throughput:
  - An entry written at clock edge k gives byte_valid=1 after edge k+2 when the FSM is idle.
  - Back-to-back entries stream at one byte per cycle with no gaps while byte_ready=1.
- Handshake:
  - byte_out and byte_valid are registered.
  - byte_out is held stable while byte_valid=1 and byte_ready=0.
  - byte_valid never deasserts without a transfer, except on reset.
- Padded bytes are also checked for 0xFF and stuffed.
- A flush of 0xFF padding (e.g. N=8 with word 0xFF......) emits FF,00.
- Reset mid-operation (any state, including STUFF):
  - Outputs return to reset values immediately.
  - No pending byte or stuff byte is emitted after release.
- busy = (FSM!=IDLE) | FIFO non-empty.

Test Plan:
- Push 0x12345678 with byte_ready=1 -> bytes 12,34,56,78 on four consecutive cycles; first byte_valid two edges after the push; busy drops afterwards.
- Push 0xFF00FF01 -> 0xFF,0x00,0x00,0xFF,0x00,0x01 (six transfers).
- eob_flush, flush_bits=5, word_in=0xA8000000 -> single byte 0xAF. Then eob_flush, flush_bits=12, word_in=0xFFF00000 -> 0xFF,0x00,0xFF,0x00. Then eob_flush, flush_bits=0 -> no output.
- FIFO_DEPTH=4, byte_ready=0, push 5 words on consecutive cycles -> in_ready=0 after the 4th, overflow=1 after the 5th, byte_out stable at the first word's MSB byte. Then release byte_ready -> exactly 16 data bytes of words 1-4 emitted in order.
- word_valid and eob_flush together, flush_bits=16, word_in=0xABCD1234 -> 0xAB,0xCD only; one FIFO entry consumed.
- Push 0xFF000000, drop rst while in STUFF -> byte_valid=0 immediately. After release: no 0x00 is emitted, busy=0, in_ready=1, overflow=0.

Source files
------------

// File: rtl/cr_byte_stuffer.sv
// Cr Huffman word FIFO to JPEG byte stream with 0xFF/0x00 stuffing.
// Flushed partial words are padded with 1s up to a byte boundary.
module cr_byte_stuffer #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        word_valid,
    input  logic [31:0] word_in,
    input  logic        eob_flush,
    input  logic [4:0]  flush_bits,
    output logic        in_ready,
    output logic [7:0]  byte_out,
    output logic        byte_valid,
    input  logic        byte_ready,
    output logic        busy,
    output logic        overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] ONE = 1;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, EMIT, STUFF} state_t;

    logic [37:0] mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr, rd_ptr, cnt, unread;
    logic        pushed_q;
    logic        push_req, push_ok, load, rel, adv, avail;
    logic [5:0]  push_nbits;
    logic [37:0] head;
    logic [31:0] head_word, pad_word;
    logic [5:0]  head_nbits;
    logic [2:0]  head_bcnt;
    state_t      state, state_n;
    logic [31:0] sreg, sreg_n;
    logic [2:0]  bcnt, bcnt_n;
    logic        ovf_q;

    always_comb begin
        push_req   = 1'b0;
        push_nbits = 6'd32;
        if (eob_flush) begin
            push_req   = (flush_bits != 5'd0);
            push_nbits = {1'b0, flush_bits};
        end else if (word_valid) begin
            push_req = 1'b1;
        end
    end

    // cnt covers the entry held in sreg until its last byte leaves
    assign in_ready = (cnt != FULL_CNT);
    assign push_ok  = push_req & in_ready;
    assign unread   = wr_ptr - rd_ptr;
    assign avail    = (unread > ONE) | ((unread == ONE) & ~pushed_q);

    assign head       = mem[rd_ptr[AW-1:0]];
    assign head_word  = head[37:6];
    assign head_nbits = head[5:0];
    assign pad_word   = head_word | (32'hFFFF_FFFF >> head_nbits);
    assign head_bcnt  = 3'((head_nbits + 6'd7) >> 3);

    always_comb begin
        state_n = state;
        sreg_n  = sreg;
        bcnt_n  = bcnt;
        load    = 1'b0;
        rel     = 1'b0;
        adv     = 1'b0;
        unique case (state)
            IDLE:  if (avail) load = 1'b1;
            EMIT: begin
                if (byte_ready) begin
                    if (sreg[31:24] == 8'hFF) state_n = STUFF;
                    else adv = 1'b1;
                end
            end
            STUFF: if (byte_ready) adv = 1'b1;
            default: state_n = IDLE;
        endcase
        if (adv) begin
            if (bcnt == 3'd1) begin
                rel = 1'b1;
                if (avail) load = 1'b1;
                else state_n = IDLE;
            end else begin
                sreg_n  = sreg << 8;
                bcnt_n  = bcnt - 3'd1;
                state_n = EMIT;
            end
        end
        if (load) begin
            sreg_n  = pad_word;
            bcnt_n  = head_bcnt;
            state_n = EMIT;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr[AW-1:0]] <= {word_in, push_nbits};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            sreg     <= '0;
            bcnt     <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            cnt      <= '0;
            pushed_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state    <= state_n;
            sreg     <= sreg_n;
            bcnt     <= bcnt_n;
            pushed_q <= push_ok;
            if (push_ok) wr_ptr <= wr_ptr + ONE;
            if (load) rd_ptr <= rd_ptr + ONE;
            if (push_ok & ~rel) cnt <= cnt + ONE;
            else if (~push_ok & rel) cnt <= cnt - ONE;
            if (push_req & ~in_ready) ovf_q <= 1'b1;
        end
    end

    assign byte_valid = (state != IDLE);
    assign byte_out   = (state == STUFF) ? 8'h00 : sreg[31:24];
    assign busy       = (state != IDLE) | (cnt != '0);
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_cr_byte_stuffer.sv
// Bench for cr_byte_stuffer: directed cases plus random traffic
// against a queue-based byte model.
module tb_cr_byte_stuffer;

    localparam int DEPTH = 4;

    logic        clk = 0;
    logic        rst = 1;
    logic        word_valid = 0;
    logic [31:0] word_in = 0;
    logic        eob_flush = 0;
    logic [4:0]  flush_bits = 0;
    logic        byte_ready = 0;
    logic        in_ready, byte_valid, busy, overflow;
    logic [7:0]  byte_out;

    cr_byte_stuffer #(.FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .word_valid(word_valid), .word_in(word_in),
        .eob_flush(eob_flush), .flush_bits(flush_bits),
        .in_ready(in_ready), .byte_out(byte_out),
        .byte_valid(byte_valid), .byte_ready(byte_ready),
        .busy(busy), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    logic [7:0] exp_q[$];
    int ent_left[$];
    logic ovf_m = 0;
    logic s_bv, s_ir, s_bs, s_ov;
    logic [7:0] s_bo;
    int xfers = 0;
    logic [7:0] last_xb = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Expected bytes of one accepted entry: pad, split, stuff after FF
    function automatic void model_push(input logic [31:0] w, input int n);
        longint unsigned padded;
        int nb;
        int len;
        logic [7:0] b;
        padded = 64'(w);
        if (n < 32) padded = padded | ((64'd1 << (32 - n)) - 64'd1);
        nb = (n + 7) / 8;
        len = 0;
        for (int i = 0; i < nb; i++) begin
            b = 8'(padded >> (24 - 8 * i));
            exp_q.push_back(b);
            len++;
            if (b == 8'hFF) begin
                exp_q.push_back(8'h00);
                len++;
            end
        end
        ent_left.push_back(len);
    endfunction

    task automatic step(input logic wv, input logic eob, input logic [4:0] fb,
                        input logic [31:0] w, input logic rdy);
        bit attempt;
        bit accepted;
        word_valid = wv;
        eob_flush  = eob;
        flush_bits = fb;
        word_in    = w;
        byte_ready = rdy;
        #3;
        s_bv = byte_valid;
        s_bo = byte_out;
        s_ir = in_ready;
        s_bs = busy;
        s_ov = overflow;
        chk("in_ready", s_ir, ent_left.size() < DEPTH);
        chk("busy", s_bs, ent_left.size() != 0);
        chk("overflow", s_ov, ovf_m);
        if (s_bv) begin
            if (exp_q.size() == 0) chk("spurious_valid", s_bv, 0);
            else chk("byte_out", s_bo, exp_q[0]);
        end
        attempt  = eob ? (fb != 0) : wv;
        accepted = attempt && (ent_left.size() < DEPTH);
        if (attempt && !accepted) ovf_m = 1;
        if (s_bv && rdy && exp_q.size() != 0) begin
            last_xb = exp_q.pop_front();
            xfers++;
            ent_left[0] = ent_left[0] - 1;
            if (ent_left[0] == 0) void'(ent_left.pop_front());
        end
        if (accepted) model_push(w, eob ? int'(fb) : 32);
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int i;
        i = 0;
        while (i < 600 && (exp_q.size() != 0 || ent_left.size() != 0)) begin
            step(0, 0, 0, 0, 1);
            i++;
        end
        chk("drain_empty", exp_q.size(), 0);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int x0;
        int i;
        logic seen;
        logic [31:0] w;
        logic [4:0] fb;

        #1 rst = 0;
        #10;
        chk("rst_byte_out", byte_out, 8'h00);
        chk("rst_valid", byte_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_overflow", overflow, 0);
        @(posedge clk);
        #1 rst = 1;

        x0 = xfers;
        step(1, 0, 0, 32'h12345678, 1);
        step(0, 0, 0, 0, 1);
        chk("lat_edge_k", s_bv, 0);
        step(0, 0, 0, 0, 1);
        chk("lat_edge_k1", s_bv, 0);
        step(0, 0, 0, 0, 1);
        chk("lat_edge_k2", s_bv, 1);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        chk("gapless_4", xfers - x0, 4);
        step(0, 0, 0, 0, 1);
        chk("busy_after", s_bs, 0);
        drain();

        x0 = xfers;
        step(1, 0, 0, 32'hFF00FF01, 1);
        drain();
        chk("stuff_count", xfers - x0, 6);

        x0 = xfers;
        step(0, 1, 5'd5, 32'hA8000000, 1);
        drain();
        chk("flush5_count", xfers - x0, 1);
        x0 = xfers;
        step(0, 1, 5'd12, 32'hFFF00000, 1);
        drain();
        chk("flush12_count", xfers - x0, 4);
        x0 = xfers;
        step(0, 1, 5'd0, 32'hFFFFFFFF, 1);
        drain();
        chk("flush0_count", xfers - x0, 0);

        x0 = xfers;
        step(1, 0, 0, 32'h01020304, 0);
        step(1, 0, 0, 32'h05060708, 0);
        step(1, 0, 0, 32'h090A0B0C, 0);
        step(1, 0, 0, 32'h0D0E0F10, 0);
        step(1, 0, 0, 32'h11121314, 0);
        chk("full_in_ready", s_ir, 0);
        step(0, 0, 0, 0, 0);
        chk("ovf_flag", s_ov, 1);
        chk("stall_byte", s_bo, 8'h01);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        drain();
        chk("ovf_bytes", xfers - x0, 16);

        x0 = xfers;
        step(1, 1, 5'd16, 32'hABCD1234, 1);
        drain();
        chk("both_count", xfers - x0, 2);

        step(1, 0, 0, 32'hFF000000, 1);
        seen = 0;
        i = 0;
        while (i < 10 && !seen) begin
            x0 = xfers;
            step(0, 0, 0, 0, 1);
            if (xfers > x0 && last_xb == 8'hFF) seen = 1;
            i++;
        end
        chk("reached_stuff", seen, 1);
        chk("stuff_valid", byte_valid, 1);
        chk("stuff_byte", byte_out, 8'h00);
        rst = 0;
        #1;
        chk("mid_rst_valid", byte_valid, 0);
        chk("mid_rst_byte", byte_out, 8'h00);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_in_ready", in_ready, 1);
        chk("mid_rst_overflow", overflow, 0);
        exp_q.delete();
        ent_left.delete();
        ovf_m = 0;
        @(posedge clk);
        #1 rst = 1;
        x0 = xfers;
        for (int k = 0; k < 8; k++) step(0, 0, 0, 0, 1);
        chk("post_rst_quiet", xfers - x0, 0);

        for (int k = 0; k < 800; k++) begin
            w = $urandom;
            if ($urandom_range(0, 3) == 0) w[31:24] = 8'hFF;
            if ($urandom_range(0, 3) == 0) w[15:8] = 8'hFF;
            fb = 5'($urandom);
            step($urandom_range(0, 99) < 45, $urandom_range(0, 9) == 0, fb, w,
                 $urandom_range(0, 3) != 0);
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
